// File: rtl/dmux8way16_stream.sv
// Registered 1-to-LANES word demultiplexer: one-entry buffer per lane, valid/ready on both sides.
// Latency 1 cycle; in_ready drops only while in_sel targets a full lane that is not being popped.
// Optional per-lane accept / drop counters when DMUX_STATS_EN is defined.
module dmux8way16_stream #(
    parameter int WIDTH = 16,
    parameter int LANES = 8,
    parameter int SEL_W = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [LANES-1:0]       out_valid,
    input  logic [LANES-1:0]       out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic [SEL_W-1:0]       stat_sel,
    output logic [15:0]            stat_count
);

    logic [LANES-1:0]       valid_q, valid_d;
    logic [LANES*WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]       hit, acc_lane, pop;
    logic                   accept;

    // An out-of-range in_sel hits no lane, so in_ready stays high and the word is dropped.
    always_comb begin
        hit      = '0;
        in_ready = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            if (in_sel == SEL_W'(i)) begin
                hit[i]   = 1'b1;
                in_ready = ~valid_q[i] | out_ready[i];
            end
        end
    end

    assign accept   = in_valid & in_ready;
    assign acc_lane = hit & {LANES{accept}};
    assign pop      = valid_q & out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int i = 0; i < LANES; i++) begin
            if (acc_lane[i]) begin
                valid_d[i]               = 1'b1;
                data_d[i*WIDTH +: WIDTH] = in_data;
            end else if (pop[i]) begin
                valid_d[i]               = 1'b0;
                data_d[i*WIDTH +: WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef DMUX_STATS_EN
    logic [15:0] cnt_q [LANES];
    logic [15:0] cnt_d [LANES];
    logic [15:0] drop_q, drop_d;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = acc_lane[i] ? cnt_q[i] + 16'd1 : cnt_q[i];
        end
        drop_d = (accept & ~|hit) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            drop_q <= drop_d;
        end
    end

    always_comb begin
        stat_count = drop_q;
        for (int i = 0; i < LANES; i++) begin
            if (stat_sel == SEL_W'(i)) begin
                stat_count = cnt_q[i];
            end
        end
    end
`else
    logic unused_stat_sel;
    assign unused_stat_sel = ^stat_sel;
    assign stat_count      = 16'h0000;
`endif

endmodule
